booth_divider: RTL and testbench



---
 rtl/booth_divider.sv | 167 ++++++++++++++++
 tb/tb_booth_divider.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/booth_divider.sv
// booth_divider: sequential radix-2 restoring divider with sign fix-up.
// Define DIV_SIGNED_EN for two's-complement operands; undefined gives unsigned operation.
module booth_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] dvr,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic             ovf
);

`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_FIX, S_DONE} state_t;

  state_t           state_q, state_nxt;
  logic [WIDTH-1:0] a_q, a_nxt;
  logic [WIDTH-1:0] b_q, b_nxt;
  logic [WIDTH-1:0] magb_q, magb_nxt;
  // The remainder is always below the divisor, so its top (WIDTH+1-th) bit is always 0 and not stored.
  logic [WIDTH-1:0] prem_q, prem_nxt;
  logic [WIDTH-1:0] qsr_q, qsr_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             negq_q, negq_nxt;
  logic             negr_q, negr_nxt;
  logic [WIDTH-1:0] quo_nxt, rem_nxt;
  logic             busy_nxt, done_nxt, dbz_nxt, ovf_nxt;

  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   shifted, trial;

  // Operand magnitudes; the most negative value maps onto itself, read as unsigned.
  assign sign_a  = SIGNED_EN & a_q[WIDTH-1];
  assign sign_b  = SIGNED_EN & b_q[WIDTH-1];
  assign mag_a   = sign_a ? WIDTH'(-a_q) : a_q;
  assign mag_b   = sign_b ? WIDTH'(-b_q) : b_q;

  // One restoring step: shift {remainder, quotient} left, then trial-subtract the divisor.
  assign shifted = {prem_q, qsr_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, magb_q};

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      magb_q  <= '0;
      prem_q  <= '0;
      qsr_q   <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      quo     <= '0;
      rem     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dbz     <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_nxt;
      a_q     <= a_nxt;
      b_q     <= b_nxt;
      magb_q  <= magb_nxt;
      prem_q  <= prem_nxt;
      qsr_q   <= qsr_nxt;
      cnt_q   <= cnt_nxt;
      negq_q  <= negq_nxt;
      negr_q  <= negr_nxt;
      quo     <= quo_nxt;
      rem     <= rem_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      dbz     <= dbz_nxt;
      ovf     <= ovf_nxt;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_nxt = state_q;
    a_nxt     = a_q;
    b_nxt     = b_q;
    magb_nxt  = magb_q;
    prem_nxt  = prem_q;
    qsr_nxt   = qsr_q;
    cnt_nxt   = cnt_q;
    negq_nxt  = negq_q;
    negr_nxt  = negr_q;
    quo_nxt   = quo;
    rem_nxt   = rem;
    dbz_nxt   = dbz;
    ovf_nxt   = ovf;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          a_nxt     = dvd;
          b_nxt     = dvr;
          dbz_nxt   = 1'b0;
          ovf_nxt   = 1'b0;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        negq_nxt = sign_a ^ sign_b;
        negr_nxt = sign_a;
        if (b_q == '0) begin
          quo_nxt   = '1;
          rem_nxt   = a_q;
          dbz_nxt   = 1'b1;
          state_nxt = S_DONE;
        end else begin
          prem_nxt  = '0;
          qsr_nxt   = mag_a;
          magb_nxt  = mag_b;
          cnt_nxt   = CNT_W'(WIDTH);
          state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (!trial[WIDTH]) begin
          prem_nxt = trial[WIDTH-1:0];
          qsr_nxt  = {qsr_q[WIDTH-2:0], 1'b1};
        end else begin
          prem_nxt = shifted[WIDTH-1:0];
          qsr_nxt  = {qsr_q[WIDTH-2:0], 1'b0};
        end
        cnt_nxt = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        quo_nxt   = negq_q ? WIDTH'(-qsr_q) : qsr_q;
        rem_nxt   = negr_q ? WIDTH'(-prem_q) : prem_q;
        ovf_nxt   = SIGNED_EN & (a_q == MIN_VAL) & (b_q == '1);
        state_nxt = S_DONE;
      end
      S_DONE: begin
        if (!enable) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt == S_LOAD) || (state_nxt == S_CALC) || (state_nxt == S_FIX);
    done_nxt = (state_nxt == S_DONE);
  end

endmodule

// File: tb/tb_booth_divider.sv
// tb_booth_divider: directed plus random operations against an arithmetic reference model.
module tb_booth_divider;

  localparam int unsigned W = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic [W-1:0] dvd, dvr;
  logic [W-1:0] quo, rem;
  logic         busy, done, dbz, ovf;

  int vectors = 0;
  int errs    = 0;

`ifdef DIV_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  booth_divider #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .enable(enable),
    .dvd   (dvd),
    .dvr   (dvr),
    .quo   (quo),
    .rem   (rem),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz),
    .ovf   (ovf)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference: integer division truncating toward zero, remainder carries the dividend's sign.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] eq, output logic [W-1:0] er,
                       output logic edbz, output logic eovf);
    int ai, bi, q, r;
    ai = (SGN && a[W-1]) ? int'(a) - (1 << W) : int'(a);
    bi = (SGN && b[W-1]) ? int'(b) - (1 << W) : int'(b);
    edbz = 1'b0;
    eovf = 1'b0;
    if (bi == 0) begin
      q = -1;
      r = ai;
      edbz = 1'b1;
    end else if (SGN && ai == -(1 << (W-1)) && bi == -1) begin
      q = -(1 << (W-1));
      r = 0;
      eovf = 1'b1;
    end else begin
      q = ai / bi;
      r = ai % bi;
    end
    eq = W'(q);
    er = W'(r);
  endtask

  // Runs one operation; hold keeps enable high past done, drop releases it mid-operation.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold, input bit drop);
    logic [W-1:0] eq, er;
    logic         edbz, eovf;
    int           lat, n, busy_cnt, both;
    model(a, b, eq, er, edbz, eovf);
    lat = edbz ? 1 : W + 2;
    @(negedge clock);
    dvd = a;
    dvr = b;
    enable = 1'b1;
    @(posedge clock);
    #1;
    n = 0;
    both = 0;
    busy_cnt = busy ? 1 : 0;
    dvd = W'($urandom);
    dvr = W'($urandom);
    while (!done && n < 20) begin
      if (drop && n == 2) begin
        @(negedge clock);
        enable = 1'b0;
      end
      @(posedge clock);
      #1;
      n++;
      if (busy) busy_cnt++;
      if (busy && done) both++;
    end
    check("latency", 32'(n), 32'(lat));
    check("busy_cycles", 32'(busy_cnt), 32'(lat));
    check("busy_done_overlap", 32'(both), 32'd0);
    check("quo", 32'(quo), 32'(eq));
    check("rem", 32'(rem), 32'(er));
    check("dbz", 32'(dbz), 32'(edbz));
    check("ovf", 32'(ovf), 32'(eovf));
    if (hold && !(drop && lat > 2)) begin
      repeat (3) @(posedge clock);
      #1;
      check("hold_done", 32'(done), 32'd1);
      check("hold_busy", 32'(busy), 32'd0);
    end
    @(negedge clock);
    enable = 1'b0;
    if (!(drop && lat > 2)) @(posedge clock);
    #1;
    if (drop && lat > 2) @(posedge clock);
    #1;
    check("idle_done", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_quo_kept", 32'(quo), 32'(eq));
    check("idle_rem_kept", 32'(rem), 32'(er));
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    dvd    = '0;
    dvr    = '0;
    #3;
    check("rst_quo", 32'(quo), 32'd0);
    check("rst_rem", 32'(rem), 32'd0);
    check("rst_flags", 32'({busy, done, dbz, ovf}), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Directed cases.
    run_op(4'h7, 4'h2, 1'b1, 1'b0);
    run_op(4'h9, 4'h2, 1'b0, 1'b0);
    run_op(4'h7, 4'hE, 1'b0, 1'b0);
    run_op(4'h7, 4'h0, 1'b1, 1'b0);
    run_op(4'h8, 4'hF, 1'b0, 1'b0);
    run_op(4'hF, 4'h4, 1'b0, 1'b1);
    run_op(4'h8, 4'h1, 1'b0, 1'b0);
    run_op(4'hF, 4'hF, 1'b0, 1'b0);

    // Asynchronous reset in the middle of CALC.
    @(negedge clock);
    dvd = 4'h7;
    dvr = 4'h3;
    enable = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_quo", 32'(quo), 32'd0);
    check("async_rst_rem", 32'(rem), 32'd0);
    check("async_rst_flags", 32'({busy, done, dbz, ovf}), 32'd0);
    enable = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    run_op(4'h7, 4'h3, 1'b0, 1'b0);

    // Reset wins over a simultaneous enable.
    @(negedge clock);
    reset = 1'b1;
    enable = 1'b1;
    @(posedge clock);
    #1;
    check("rst_vs_enable_busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    enable = 1'b0;

    // Random operations.
    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), (i % 8 == 0) ? 4'h0 : W'($urandom),
             bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
